// File: rtl/reaction_ctrl.sv
// reaction_ctrl: sequencer for the F1-lights reaction game.
// Fires one trigger into the lights FSM, waits for the bar to fill and then
// go dark, times the player's reaction in millisecond ticks, and reports a
// result, a false start or a timeout. Keeps the best valid time until reset
// or clear_best.
module reaction_ctrl #(
    parameter int CNT_W      = 12,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             react,
    input  logic             clear_best,
    input  logic [7:0]       lights,
    input  logic             ms_tick,
    output logic             fsm_trigger,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] reaction_ms,
    output logic [CNT_W-1:0] best_ms,
    output logic             best_valid,
    output logic             false_start,
    output logic             timeout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_LIGHTS = 3'd2,
        ST_TIMING = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_MS);

    state_t             state_r;
    logic               start_q_r;
    logic               react_q_r;
    logic               seen_full_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               fsm_trigger_r;
    logic               busy_r;
    logic               result_valid_r;
    logic [CNT_W-1:0]   reaction_ms_r;
    logic [CNT_W-1:0]   best_ms_r;
    logic               best_valid_r;
    logic               false_start_r;
    logic               timeout_r;

    logic               start_rise_s;
    logic               react_rise_s;
    logic [CNT_W-1:0]   cnt_next_s;

    assign start_rise_s = start & ~start_q_r;
    assign react_rise_s = react & ~react_q_r;
    assign cnt_next_s   = cnt_r + ONE_C;

    // Game sequencer: state, edge-detect history, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            start_q_r      <= 1'b0;
            react_q_r      <= 1'b0;
            seen_full_r    <= 1'b0;
            cnt_r          <= ZERO_C;
            fsm_trigger_r  <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            reaction_ms_r  <= ZERO_C;
            best_ms_r      <= ZERO_C;
            best_valid_r   <= 1'b0;
            false_start_r  <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            start_q_r      <= start;
            react_q_r      <= react;
            fsm_trigger_r  <= 1'b0;
            result_valid_r <= 1'b0;

            // Clear first so that a same-cycle DONE update below overrides it.
            if (clear_best) begin
                best_valid_r <= 1'b0;
                best_ms_r    <= ZERO_C;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        false_start_r <= 1'b0;
                        timeout_r     <= 1'b0;
                        fsm_trigger_r <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    seen_full_r <= 1'b0;
                    state_r     <= ST_LIGHTS;
                end

                ST_LIGHTS: begin
                    // A press before the bar goes dark is a false start, even
                    // in the very cycle the lights reach zero.
                    if (react_rise_s) begin
                        false_start_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_FAULT;
                    end else if (seen_full_r && (lights == 8'h00)) begin
                        cnt_r   <= ZERO_C;
                        state_r <= ST_TIMING;
                    end else if (lights == 8'hFF) begin
                        seen_full_r <= 1'b1;
                    end
                end

                ST_TIMING: begin
                    // The press wins over a same-cycle tick, so the latched
                    // value is the count before that tick is applied.
                    if (react_rise_s) begin
                        reaction_ms_r  <= cnt_r;
                        result_valid_r <= 1'b1;
                        busy_r         <= 1'b0;
                        state_r        <= ST_DONE;
                    end else if (ms_tick) begin
                        cnt_r <= cnt_next_s;
                        if (cnt_next_s == TIMEOUT_C) begin
                            timeout_r <= 1'b1;
                            busy_r    <= 1'b0;
                            state_r   <= ST_FAULT;
                        end
                    end
                end

                ST_DONE: begin
                    if (!best_valid_r || (reaction_ms_r < best_ms_r)) begin
                        best_ms_r    <= reaction_ms_r;
                        best_valid_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                end

                ST_FAULT: begin
                    state_r <= ST_IDLE;
                end

                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_trigger  = fsm_trigger_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign reaction_ms  = reaction_ms_r;
    assign best_ms      = best_ms_r;
    assign best_valid   = best_valid_r;
    assign false_start  = false_start_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed testbench for reaction_ctrl with a short timeout so the abort
// path is reachable in a few cycles.
module tb_reaction_ctrl;

    localparam int CNT_W = 12;

    logic             clk;
    logic             rst;
    logic             start;
    logic             react;
    logic             clear_best;
    logic [7:0]       lights;
    logic             ms_tick;
    logic             fsm_trigger;
    logic             busy;
    logic             result_valid;
    logic [CNT_W-1:0] reaction_ms;
    logic [CNT_W-1:0] best_ms;
    logic             best_valid;
    logic             false_start;
    logic             timeout;

    int checks;
    int errors;
    int trig_cnt;
    int rv_cnt;

    reaction_ctrl #(.CNT_W(CNT_W), .TIMEOUT_MS(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .react        (react),
        .clear_best   (clear_best),
        .lights       (lights),
        .ms_tick      (ms_tick),
        .fsm_trigger  (fsm_trigger),
        .busy         (busy),
        .result_valid (result_valid),
        .reaction_ms  (reaction_ms),
        .best_ms      (best_ms),
        .best_valid   (best_valid),
        .false_start  (false_start),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (fsm_trigger)  trig_cnt <= trig_cnt + 1;
        if (result_valid) rv_cnt   <= rv_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press start; the trigger must be high for exactly the ARM cycle.
    task automatic do_start();
        start = 1'b1;
        cyc(1);
        check_eq("trig_high", {31'd0, fsm_trigger}, 32'd1);
        start = 1'b0;
        cyc(1);
        check_eq("trig_low", {31'd0, fsm_trigger}, 32'd0);
    endtask

    task automatic run_lights();
        logic [7:0] seq [0:8];
        seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        for (int i = 0; i < 9; i++) begin
            lights = seq[i];
            cyc(1);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            ms_tick = 1'b1;
            cyc(1);
            ms_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic press();
        react = 1'b1;
        cyc(1);
        react = 1'b0;
        cyc(1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_trig"}, {31'd0, fsm_trigger}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_rv"}, {31'd0, result_valid}, 32'd0);
        check_eq({tag, "_react_ms"}, {20'd0, reaction_ms}, 32'd0);
        check_eq({tag, "_best_ms"}, {20'd0, best_ms}, 32'd0);
        check_eq({tag, "_best_valid"}, {31'd0, best_valid}, 32'd0);
        check_eq({tag, "_false_start"}, {31'd0, false_start}, 32'd0);
        check_eq({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        trig_cnt   = 0;
        rv_cnt     = 0;
        rst        = 1'b0;
        start      = 1'b0;
        react      = 1'b0;
        clear_best = 1'b0;
        lights     = 8'h00;
        ms_tick    = 1'b0;
        cyc(3);
        check_all_zero("reset");
        rst = 1'b1;
        cyc(2);

        // Run 1: reaction of 5 ticks becomes the first best.
        do_start();
        check_eq("run1_busy", {31'd0, busy}, 32'd1);
        check_eq("run1_trig_cnt", trig_cnt, 32'd1);
        run_lights();
        check_eq("run1_busy_timing", {31'd0, busy}, 32'd1);
        tick(5);
        press();
        check_eq("run1_rv_cnt", rv_cnt, 32'd1);
        check_eq("run1_reaction", {20'd0, reaction_ms}, 32'd5);
        check_eq("run1_best", {20'd0, best_ms}, 32'd5);
        check_eq("run1_best_valid", {31'd0, best_valid}, 32'd1);
        check_eq("run1_busy_end", {31'd0, busy}, 32'd0);

        // Run 2 improves the best, run 3 does not.
        do_start(); run_lights(); tick(3); press();
        check_eq("run2_reaction", {20'd0, reaction_ms}, 32'd3);
        check_eq("run2_best", {20'd0, best_ms}, 32'd3);
        do_start(); run_lights(); tick(7); press();
        check_eq("run3_reaction", {20'd0, reaction_ms}, 32'd7);
        check_eq("run3_best", {20'd0, best_ms}, 32'd3);
        check_eq("run3_rv_cnt", rv_cnt, 32'd3);

        // React coinciding with the 4th tick latches the pre-tick count.
        do_start(); run_lights(); tick(3);
        ms_tick = 1'b1;
        react   = 1'b1;
        cyc(1);
        ms_tick = 1'b0;
        react   = 1'b0;
        cyc(1);
        check_eq("coll_reaction", {20'd0, reaction_ms}, 32'd3);
        check_eq("coll_rv_cnt", rv_cnt, 32'd4);

        // False start while the bar is still filling.
        do_start();
        for (int i = 0; i < 5; i++) begin
            lights = (8'h02 << i) - 8'h01;
            cyc(1);
        end
        lights = 8'h3F;
        react  = 1'b1;
        cyc(1);
        react  = 1'b0;
        check_eq("fs_flag", {31'd0, false_start}, 32'd1);
        check_eq("fs_busy", {31'd0, busy}, 32'd0);
        lights = 8'h00;
        cyc(2);
        check_eq("fs_rv_cnt", rv_cnt, 32'd4);
        check_eq("fs_reaction", {20'd0, reaction_ms}, 32'd3);
        check_eq("fs_sticky", {31'd0, false_start}, 32'd1);

        // Timeout after the 10th tick.
        do_start();
        check_eq("to_fs_cleared", {31'd0, false_start}, 32'd0);
        run_lights();
        tick(9);
        check_eq("to_not_yet", {31'd0, timeout}, 32'd0);
        check_eq("to_busy_9", {31'd0, busy}, 32'd1);
        tick(1);
        check_eq("to_flag", {31'd0, timeout}, 32'd1);
        check_eq("to_busy", {31'd0, busy}, 32'd0);
        check_eq("to_rv_cnt", rv_cnt, 32'd4);
        check_eq("to_reaction", {20'd0, reaction_ms}, 32'd3);

        // Next start clears timeout; a start during LIGHTS is ignored.
        do_start();
        check_eq("to_cleared", {31'd0, timeout}, 32'd0);
        check_eq("ign_trig_before", trig_cnt, 32'd7);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        check_eq("ign_trig_cnt", trig_cnt, 32'd7);
        check_eq("ign_busy", {31'd0, busy}, 32'd1);

        // Reset during TIMING aborts with no result pulse.
        run_lights();
        tick(2);
        rst = 1'b0;
        cyc(2);
        check_all_zero("midrst");
        rst = 1'b1;
        cyc(2);
        check_eq("midrst_rv_cnt", rv_cnt, 32'd4);

        // Back in IDLE: a fresh run works and rebuilds best from scratch.
        do_start(); run_lights(); tick(6); press();
        check_eq("post_reaction", {20'd0, reaction_ms}, 32'd6);
        check_eq("post_best", {20'd0, best_ms}, 32'd6);
        check_eq("post_best_valid", {31'd0, best_valid}, 32'd1);

        // clear_best wipes the record.
        clear_best = 1'b1;
        cyc(1);
        clear_best = 1'b0;
        check_eq("clr_best_valid", {31'd0, best_valid}, 32'd0);
        check_eq("clr_best_ms", {20'd0, best_ms}, 32'd0);
        check_eq("clr_reaction", {20'd0, reaction_ms}, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
